// File: rtl/accumulator_unit.sv
// Parametrised datapath accumulator: ALU op into ACC with Z/N/C/V flags and a
// LIFO save/restore stack of {ACC,flags} for call/interrupt context.
module accumulator_unit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SAT_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_ac,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = WIDTH + 4;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } op_e;

    // flags packed as {z, n, c, v}
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic [EW-1:0]    stk_q [DEPTH];

    logic [WIDTH-1:0] alu_res_c;
    logic [3:0]       alu_flags_c;
    logic             wr_en_c;
    logic [AW-1:0]    wr_idx_c;
    logic [AW-1:0]    rd_idx_c;

    // ALU: result plus flags; saturation applied after overflow detection
    always_comb begin
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        ext = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op_e'(op))
            OP_LOAD: res = data_in;
            OP_ADD: begin
                ext = {1'b0, acc_q} + {1'b0, data_in};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (acc_q[WIDTH-1] == data_in[WIDTH-1]) &&
                      (res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
                ext = {1'b0, acc_q} - {1'b0, data_in};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (acc_q[WIDTH-1] != data_in[WIDTH-1]) &&
                      (res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND: res = acc_q & data_in;
            OP_OR:  res = acc_q | data_in;
            OP_XOR: res = acc_q ^ data_in;
            OP_SHL: begin
                res = {acc_q[WIDTH-2:0], 1'b0};
                c   = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, acc_q[WIDTH-1:1]};
                c   = acc_q[0];
            end
            default: res = data_in;
        endcase
        // overflow direction follows the sign of A for both ADD and SUB
        if ((SAT_EN != 0) && v) begin
            res = acc_q[WIDTH-1] ? SMIN : SMAX;
        end
        alu_res_c   = res;
        alu_flags_c = {(res == '0), res[WIDTH-1], c, v};
    end

    assign wr_idx_c = AW'(cnt_q);
    assign rd_idx_c = AW'(cnt_q - CW'(1));
    assign wr_en_c  = push && !pop && (cnt_q != CW'(DEPTH));

    // command arbitration: pop > push; ld_ac runs unless a real pop occurs
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (pop) begin
            if (cnt_q != '0) begin
                {acc_d, flags_d} = stk_q[rd_idx_c];
                cnt_d            = cnt_q - CW'(1);
            end else begin
                err_d = 1'b1;
                if (ld_ac) begin
                    acc_d   = alu_res_c;
                    flags_d = alu_flags_c;
                end
            end
        end else begin
            if (push) begin
                if (cnt_q != CW'(DEPTH)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            if (ld_ac) begin
                acc_d   = alu_res_c;
                flags_d = alu_flags_c;
            end
        end
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // stack storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            stk_q[wr_idx_c] <= {acc_q, flags_q};
        end
    end

    assign acc_out   = acc_q;
    assign flag_z    = flags_q[3];
    assign flag_n    = flags_q[2];
    assign flag_c    = flags_q[1];
    assign flag_v    = flags_q[0];
    assign stk_full  = full_q;
    assign stk_empty = empty_q;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed bench for accumulator_unit: expectations queued at drive time and
// checked after the edge, with a second SAT_EN=1 instance for saturation.
module tb_accumulator_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_ac;
    logic [2:0] op;
    logic [7:0] data_in;
    logic       push;
    logic       pop;

    logic [7:0] acc_out, s_acc_out;
    logic flag_z, flag_n, flag_c, flag_v, stk_full, stk_empty, stk_err;
    logic s_z, s_n, s_c, s_v, s_full, s_empty, s_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0] acc;
        logic [3:0] flags;
        logic [2:0] stk;
        bit         chk_sat;
        logic [7:0] sat_acc;
        logic [3:0] sat_flags;
        string      tag;
    } exp_t;

    exp_t sb[$];

    accumulator_unit #(.WIDTH(8), .DEPTH(4), .SAT_EN(0)) u_dut (
        .clk(clk), .rst(rst), .ld_ac(ld_ac), .op(op), .data_in(data_in),
        .push(push), .pop(pop), .acc_out(acc_out),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    accumulator_unit #(.WIDTH(8), .DEPTH(4), .SAT_EN(1)) u_sat (
        .clk(clk), .rst(rst), .ld_ac(ld_ac), .op(op), .data_in(data_in),
        .push(push), .pop(pop), .acc_out(s_acc_out),
        .flag_z(s_z), .flag_n(s_n), .flag_c(s_c), .flag_v(s_v),
        .stk_full(s_full), .stk_empty(s_empty), .stk_err(s_err)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input logic [7:0] a, input logic [3:0] f,
                              input logic [2:0] stk, input string tag);
        exp_t e;
        e.acc = a; e.flags = f; e.stk = stk;
        e.chk_sat = 1'b0; e.sat_acc = '0; e.sat_flags = '0; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs, input logic [7:0] exp_v, input string tag);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        check(acc_out, e.acc, {e.tag, ".acc"});
        check({4'h0, flag_z, flag_n, flag_c, flag_v}, {4'h0, e.flags}, {e.tag, ".zncv"});
        check({5'h0, stk_full, stk_empty, stk_err}, {5'h0, e.stk}, {e.tag, ".full_empty_err"});
        if (e.chk_sat) begin
            check(s_acc_out, e.sat_acc, {e.tag, ".sat_acc"});
            check({4'h0, s_z, s_n, s_c, s_v}, {4'h0, e.sat_flags}, {e.tag, ".sat_zncv"});
        end
    endtask

    // one command cycle: drive at negedge, queue expectation, check after posedge
    task automatic step(input logic l, input logic [2:0] o, input logic [7:0] d,
                        input logic ps, input logic pp,
                        input logic [7:0] a, input logic [3:0] f,
                        input logic [2:0] stk, input string tag);
        @(negedge clk);
        ld_ac = l; op = o; data_in = d; push = ps; pop = pp;
        expect_out(a, f, stk, tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    localparam logic [2:0] LD = 3'b000, ADD = 3'b001, SUB = 3'b010,
                           SHL = 3'b110, SHR = 3'b111;
    // stk field is {full, empty, err}
    localparam logic [2:0] S_EMPTY = 3'b010, S_MID = 3'b000, S_FULL = 3'b100;

    initial begin
        exp_t e;
        rst = 1'b0; ld_ac = 1'b0; op = '0; data_in = '0; push = 1'b0; pop = 1'b0;
        repeat (2) @(negedge clk);
        expect_out(8'h00, 4'b0000, S_EMPTY, "reset_state");
        compare();
        rst = 1'b1;

        // 1: asynchronous reset mid-cycle
        step(1, LD, 8'h3C, 0, 0, 8'h3C, 4'b0000, S_EMPTY, "load_3c");
        #2;
        ld_ac = 1'b0;
        rst = 1'b0;
        expect_out(8'h00, 4'b0000, S_EMPTY, "async_reset");
        #1;
        compare();
        @(negedge clk);
        rst = 1'b1;

        // 2: hold and add
        step(1, LD,  8'hA5, 0, 0, 8'hA5, 4'b0100, S_EMPTY, "load_a5");
        step(0, ADD, 8'h5A, 0, 0, 8'hA5, 4'b0100, S_EMPTY, "hold");
        step(1, ADD, 8'h5A, 0, 0, 8'hFF, 4'b0100, S_EMPTY, "add_a5_5a");

        // 3: arithmetic edges, saturating instance checked on overflow
        step(1, LD, 8'h7F, 0, 0, 8'h7F, 4'b0000, S_EMPTY, "load_7f");
        @(negedge clk);
        ld_ac = 1'b1; op = ADD; data_in = 8'h01; push = 1'b0; pop = 1'b0;
        e.acc = 8'h80; e.flags = 4'b0101; e.stk = S_EMPTY;
        e.chk_sat = 1'b1; e.sat_acc = 8'h7F; e.sat_flags = 4'b0001; e.tag = "add_ovf";
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
        step(1, LD,  8'h00, 0, 0, 8'h00, 4'b1000, S_EMPTY, "load_00");
        step(1, SUB, 8'h01, 0, 0, 8'hFF, 4'b0110, S_EMPTY, "sub_borrow");
        step(1, LD,  8'hFF, 0, 0, 8'hFF, 4'b0100, S_EMPTY, "load_ff");
        step(1, ADD, 8'h01, 0, 0, 8'h00, 4'b1010, S_EMPTY, "add_carry");

        // 4: shifts ignore data_in
        step(1, LD,  8'h81, 0, 0, 8'h81, 4'b0100, S_EMPTY, "load_81");
        step(1, SHL, 8'hFF, 0, 0, 8'h02, 4'b0010, S_EMPTY, "shl");
        step(1, SHR, 8'hFF, 0, 0, 8'h01, 4'b0000, S_EMPTY, "shr1");
        step(1, SHR, 8'hFF, 0, 0, 8'h00, 4'b1010, S_EMPTY, "shr2");

        // 5: fill, overflow, drain, underflow
        step(1, LD, 8'h11, 0, 0, 8'h11, 4'b0000, S_EMPTY, "load_11");
        step(0, LD, 8'h00, 1, 0, 8'h11, 4'b0000, S_MID,   "push1");
        step(1, LD, 8'h22, 0, 0, 8'h22, 4'b0000, S_MID,   "load_22");
        step(0, LD, 8'h00, 1, 0, 8'h22, 4'b0000, S_MID,   "push2");
        step(1, LD, 8'h33, 0, 0, 8'h33, 4'b0000, S_MID,   "load_33");
        step(0, LD, 8'h00, 1, 0, 8'h33, 4'b0000, S_MID,   "push3");
        step(1, LD, 8'h44, 0, 0, 8'h44, 4'b0000, S_MID,   "load_44");
        step(0, LD, 8'h00, 1, 0, 8'h44, 4'b0000, S_FULL,  "push4_full");
        step(0, LD, 8'h00, 1, 0, 8'h44, 4'b0000, 3'b101,  "push5_err");
        step(1, LD, 8'h80, 0, 0, 8'h80, 4'b0100, S_FULL,  "err_pulse_end");
        step(0, LD, 8'h00, 0, 1, 8'h44, 4'b0000, S_MID,   "pop_44");
        step(0, LD, 8'h00, 0, 1, 8'h33, 4'b0000, S_MID,   "pop_33");
        step(0, LD, 8'h00, 0, 1, 8'h22, 4'b0000, S_MID,   "pop_22");
        step(0, LD, 8'h00, 0, 1, 8'h11, 4'b0000, S_EMPTY, "pop_11");
        step(0, LD, 8'h00, 0, 1, 8'h11, 4'b0000, 3'b011,  "pop5_err");

        // 6: simultaneous commands
        step(1, LD, 8'h10, 0, 0, 8'h10, 4'b0000, S_EMPTY, "load_10");
        step(1, LD, 8'h99, 1, 0, 8'h99, 4'b0100, S_MID,   "push_load_99");
        step(1, LD, 8'h55, 0, 1, 8'h10, 4'b0000, S_EMPTY, "pop_beats_ld");
        step(0, LD, 8'h00, 1, 0, 8'h10, 4'b0000, S_MID,   "push_10");
        step(1, LD, 8'h77, 0, 0, 8'h77, 4'b0000, S_MID,   "load_77");
        step(0, LD, 8'h00, 1, 1, 8'h10, 4'b0000, S_EMPTY, "push_pop_pop_only");
        step(1, LD, 8'h66, 0, 1, 8'h66, 4'b0000, 3'b011,  "ld_with_bad_pop");
        step(0, LD, 8'h00, 1, 0, 8'h66, 4'b0000, S_MID,   "push_66");

        // reset asserted while a push is pending
        @(negedge clk);
        ld_ac = 1'b0; push = 1'b1; pop = 1'b0;
        #2;
        rst = 1'b0;
        expect_out(8'h00, 4'b0000, S_EMPTY, "reset_during_push");
        #1;
        compare();
        @(posedge clk);
        #1;
        expect_out(8'h00, 4'b0000, S_EMPTY, "reset_held_push");
        compare();
        @(negedge clk);
        push = 1'b0;
        rst = 1'b1;
        step(0, LD, 8'h00, 0, 1, 8'h00, 4'b0000, 3'b011, "pop_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
